dso_ctrl_regs: RTL and testbench

//  Command/register front-end for the DSO datapath, in the sys_clk domain. Parses 5-byte frames from a

---
 rtl/dso_ctrl_regs_pkg.sv | 39 +++
 rtl/dso_ctrl_regs_resp_ser.sv | 76 +++++++
 rtl/dso_ctrl_regs.sv | 241 ++++++++++++++++++++++++
 tb/tb_dso_ctrl_regs.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_ctrl_regs_pkg.sv
// Shared constants for the DSO control-register front-end: frame headers,
// register addresses, reset values and the frame-parser state encoding.
package dso_ctrl_regs_pkg;

  localparam logic [7:0] DEF_HDR_RX = 8'h55;
  localparam logic [7:0] DEF_HDR_TX = 8'hAA;

  localparam logic [6:0] ADDR_TRIG_LEVEL = 7'h00;
  localparam logic [6:0] ADDR_DECI_RATE  = 7'h01;
  localparam logic [6:0] ADDR_MODE       = 7'h02;
  localparam logic [6:0] ADDR_V_SCALE    = 7'h03;
  localparam logic [6:0] ADDR_TRIG_LINE  = 7'h04;
  localparam logic [6:0] ADDR_FREQ_LO    = 7'h10;
  localparam logic [6:0] ADDR_FREQ_HI    = 7'h11;
  localparam logic [6:0] ADDR_VPP        = 7'h12;
  localparam logic [6:0] ADDR_MAX_MIN    = 7'h13;

  localparam logic [7:0]  RST_TRIG_LEVEL = 8'd127;
  localparam logic [9:0]  RST_DECI_RATE  = 10'd1;
  // {fir_en, fft_en, trig_edge, wave_run}
  localparam logic [3:0]  RST_MODE       = 4'b0011;
  localparam logic [4:0]  RST_V_SCALE    = 5'h12;
  localparam logic [11:0] RST_TRIG_LINE  = 12'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CHK  = 3'd4,
    ST_RESP = 3'd5
  } parse_state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/dso_ctrl_regs_resp_ser.sv
// Five-byte response serializer: HDR, CMD, VHI, VLO, CHK over a valid/ready port,
// with a done pulse on acceptance of the last byte.
module dso_resp_ser
  import dso_ctrl_regs_pkg::*;
#(
  parameter logic [7:0] HDR_TX = DEF_HDR_TX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        abort,
  input  logic [7:0]  cmd,
  input  logic [15:0] value,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic       valid_r;
  logic [7:0] data_r;
  logic [2:0] idx_r;
  logic [7:0] cmd_r;
  logic [7:0] vhi_r;
  logic [7:0] vlo_r;
  logic [7:0] next_byte_s;
  logic       last_s;

  assign last_s   = (idx_r == 3'd4);
  assign done     = valid_r && tx_ready && last_s;
  assign tx_valid = valid_r;
  assign tx_data  = data_r;

  // Byte that follows the one currently presented.
  always_comb begin
    next_byte_s = 8'h00;
    case (idx_r)
      3'd0:    next_byte_s = cmd_r;
      3'd1:    next_byte_s = vhi_r;
      3'd2:    next_byte_s = vlo_r;
      3'd3:    next_byte_s = frame_chk(cmd_r, vhi_r, vlo_r);
      default: next_byte_s = 8'h00;
    endcase
  end

  // Load, advance on handshake, abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= 8'h00;
      idx_r   <= 3'd0;
      cmd_r   <= 8'h00;
      vhi_r   <= 8'h00;
      vlo_r   <= 8'h00;
    end else if (abort) begin
      valid_r <= 1'b0;
      idx_r   <= 3'd0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= HDR_TX;
      idx_r   <= 3'd0;
      cmd_r   <= cmd;
      vhi_r   <= value[15:8];
      vlo_r   <= value[7:0];
    end else if (valid_r && tx_ready) begin
      if (last_s) begin
        valid_r <= 1'b0;
        idx_r   <= 3'd0;
      end else begin
        idx_r  <= idx_r + 3'd1;
        data_r <= next_byte_s;
      end
    end
  end

endmodule

// File: rtl/dso_ctrl_regs.sv
// DSO command front-end: parses 5-byte frames from the UART byte stream, owns the
// scope control registers and answers read frames through dso_resp_ser.
module dso_ctrl_regs
  import dso_ctrl_regs_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd5_000_000,
  parameter logic [7:0]  HDR_RX      = DEF_HDR_RX,
  parameter logic [7:0]  HDR_TX      = DEF_HDR_TX
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic [19:0] ad_freq,
  input  logic [7:0]  ad_vpp,
  input  logic [7:0]  ad_max,
  input  logic [7:0]  ad_min,
  output logic [7:0]  trig_level,
  output logic [9:0]  deci_rate,
  output logic        wave_run,
  output logic        trig_edge,
  output logic        fft_en,
  output logic        fir_en,
  output logic [4:0]  v_scale,
  output logic [11:0] trig_line,
  output logic [7:0]  err_cnt
);

  parse_state_t state_r;
  parse_state_t state_nx_s;

  logic [7:0]  cmd_r;
  logic [7:0]  dhi_r;
  logic [7:0]  dlo_r;
  logic [31:0] tmo_cnt_r;
  logic [7:0]  err_cnt_r;
  logic [7:0]  trig_level_r;
  logic [9:0]  deci_rate_r;
  logic [3:0]  mode_r;
  logic [4:0]  v_scale_r;
  logic [11:0] trig_line_r;

  logic [6:0]  addr_s;
  logic [15:0] rd_val_s;
  logic [9:0]  deci_wr_s;
  logic        readable_s;
  logic        writable_s;
  logic        chk_ok_s;
  logic        in_frame_s;
  logic        tmo_hit_s;
  logic        wr_en_s;
  logic        rd_en_s;
  logic        err_inc_s;
  logic        ser_abort_s;
  logic        ser_done_s;

  assign addr_s     = cmd_r[6:0];
  assign chk_ok_s   = (frame_chk(cmd_r, dhi_r, dlo_r) == rx_data);
  assign writable_s = (addr_s <= ADDR_TRIG_LINE);
  assign in_frame_s = (state_r == ST_CMD) || (state_r == ST_DHI) ||
                      (state_r == ST_DLO) || (state_r == ST_CHK);
  assign tmo_hit_s  = in_frame_s && (tmo_cnt_r == (TIMEOUT_CYC - 32'd1));
  assign deci_wr_s  = {dhi_r[1:0], dlo_r};

  // Readback mux for every readable address.
  always_comb begin
    rd_val_s   = 16'h0000;
    readable_s = 1'b1;
    case (addr_s)
      ADDR_TRIG_LEVEL: rd_val_s = {8'h00, trig_level_r};
      ADDR_DECI_RATE:  rd_val_s = {6'd0, deci_rate_r};
      ADDR_MODE:       rd_val_s = {12'd0, mode_r};
      ADDR_V_SCALE:    rd_val_s = {11'd0, v_scale_r};
      ADDR_TRIG_LINE:  rd_val_s = {4'd0, trig_line_r};
      ADDR_FREQ_LO:    rd_val_s = ad_freq[15:0];
      ADDR_FREQ_HI:    rd_val_s = {12'd0, ad_freq[19:16]};
      ADDR_VPP:        rd_val_s = {8'h00, ad_vpp};
      ADDR_MAX_MIN:    rd_val_s = {ad_max, ad_min};
      default:         readable_s = 1'b0;
    endcase
  end

  // Parser state register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Parser next state and frame verdict; a byte arriving on the timeout cycle wins.
  always_comb begin
    state_nx_s  = state_r;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    err_inc_s   = 1'b0;
    ser_abort_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && (rx_data == HDR_RX)) begin
          state_nx_s = ST_CMD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CMD, ST_DHI, ST_DLO: begin
        if (rx_valid) begin
          state_nx_s = (state_r == ST_CMD) ? ST_DHI :
                       (state_r == ST_DHI) ? ST_DLO : ST_CHK;
        end else if (tmo_hit_s) begin
          state_nx_s = ST_IDLE;
          err_inc_s  = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          state_nx_s = ST_IDLE;
          if (!chk_ok_s) begin
            err_inc_s = 1'b1;
          end else if (cmd_r[7]) begin
            if (readable_s) begin
              rd_en_s    = 1'b1;
              state_nx_s = ST_RESP;
            end else begin
              err_inc_s = 1'b1;
            end
          end else if (writable_s) begin
            wr_en_s = 1'b1;
          end else begin
            err_inc_s = 1'b1;
          end
        end else if (tmo_hit_s) begin
          state_nx_s = ST_IDLE;
          err_inc_s  = 1'b1;
        end else begin
          state_nx_s = ST_CHK;
        end
      end
      ST_RESP: begin
        if (rx_valid) begin
          state_nx_s  = ST_IDLE;
          err_inc_s   = 1'b1;
          ser_abort_s = 1'b1;
        end else if (ser_done_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Frame byte capture.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cmd_r <= 8'h00;
      dhi_r <= 8'h00;
      dlo_r <= 8'h00;
    end else if (rx_valid) begin
      case (state_r)
        ST_CMD:  cmd_r <= rx_data;
        ST_DHI:  dhi_r <= rx_data;
        ST_DLO:  dlo_r <= rx_data;
        default: cmd_r <= cmd_r;
      endcase
    end
  end

  // Inter-byte idle counter, only live while a frame is open.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      tmo_cnt_r <= 32'd0;
    end else if (in_frame_s && !rx_valid && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end else begin
      tmo_cnt_r <= 32'd0;
    end
  end

  // Control register file.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      trig_level_r <= RST_TRIG_LEVEL;
      deci_rate_r  <= RST_DECI_RATE;
      mode_r       <= RST_MODE;
      v_scale_r    <= RST_V_SCALE;
      trig_line_r  <= RST_TRIG_LINE;
    end else if (wr_en_s) begin
      case (addr_s)
        ADDR_TRIG_LEVEL: trig_level_r <= dlo_r;
        ADDR_DECI_RATE:  deci_rate_r  <= (deci_wr_s == 10'd0) ? 10'd1 : deci_wr_s;
        ADDR_MODE:       mode_r       <= dlo_r[3:0];
        ADDR_V_SCALE:    v_scale_r    <= dlo_r[4:0];
        ADDR_TRIG_LINE:  trig_line_r  <= {dhi_r[3:0], dlo_r};
        default:         trig_level_r <= trig_level_r;
      endcase
    end
  end

  // Saturating reject counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (err_inc_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  dso_resp_ser #(.HDR_TX(HDR_TX)) u_resp_ser (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (rd_en_s),
    .abort    (ser_abort_s),
    .cmd      (cmd_r),
    .value    (rd_val_s),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .done     (ser_done_s)
  );

  assign trig_level = trig_level_r;
  assign deci_rate  = deci_rate_r;
  assign wave_run   = mode_r[0];
  assign trig_edge  = mode_r[1];
  assign fft_en     = mode_r[2];
  assign fir_en     = mode_r[3];
  assign v_scale    = v_scale_r;
  assign trig_line  = trig_line_r;
  assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_dso_ctrl_regs.sv
// Self-checking bench for dso_ctrl_regs: directed frames plus randomized frames
// scored against an address-indexed register model.
module tb_dso_ctrl_regs;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [19:0] ad_freq;
  logic [7:0]  ad_vpp;
  logic [7:0]  ad_max;
  logic [7:0]  ad_min;
  logic [7:0]  trig_level;
  logic [9:0]  deci_rate;
  logic        wave_run;
  logic        trig_edge;
  logic        fft_en;
  logic        fir_en;
  logic [4:0]  v_scale;
  logic [11:0] trig_line;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned mreg[5];
  int unsigned merr;
  logic [7:0]  exp_resp[5];
  logic [7:0]  got[5];

  dso_ctrl_regs #(.TIMEOUT_CYC(32'd100)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (sys_rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ad_freq    (ad_freq),
    .ad_vpp     (ad_vpp),
    .ad_max     (ad_max),
    .ad_min     (ad_min),
    .trig_level (trig_level),
    .deci_rate  (deci_rate),
    .wave_run   (wave_run),
    .trig_edge  (trig_edge),
    .fft_en     (fft_en),
    .fir_en     (fir_en),
    .v_scale    (v_scale),
    .trig_line  (trig_line),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mreg[0] = 127; mreg[1] = 1; mreg[2] = 3; mreg[3] = 18; mreg[4] = 0;
    merr = 0;
  endtask

  task automatic model_err();
    if (merr < 255) merr++;
  endtask

  // Applies one frame to the model; returns 1 when a response is expected.
  task automatic model_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                             input logic [7:0] k, output bit resp);
    int unsigned a;
    int unsigned d;
    int unsigned v;
    logic [7:0] vh;
    logic [7:0] vl;
    resp = 0;
    a = c & 8'h7F;
    d = h * 256 + l;
    if ((c ^ h ^ l) != k) begin
      model_err();
    end else if (c[7]) begin
      if (a < 5)        v = mreg[a];
      else if (a == 16) v = ad_freq % 65536;
      else if (a == 17) v = ad_freq / 65536;
      else if (a == 18) v = ad_vpp;
      else if (a == 19) v = ad_max * 256 + ad_min;
      else              v = 32'hFFFF_FFFF;
      if (v == 32'hFFFF_FFFF) begin
        model_err();
      end else begin
        resp = 1;
        vh = 8'(v / 256);
        vl = 8'(v % 256);
        exp_resp[0] = 8'hAA; exp_resp[1] = c; exp_resp[2] = vh; exp_resp[3] = vl;
        exp_resp[4] = c ^ vh ^ vl;
      end
    end else if (a == 0) mreg[0] = d % 256;
    else if (a == 1)     mreg[1] = ((d % 1024) == 0) ? 1 : d % 1024;
    else if (a == 2)     mreg[2] = d % 16;
    else if (a == 3)     mreg[3] = d % 32;
    else if (a == 4)     mreg[4] = d % 4096;
    else                 model_err();
  endtask

  task automatic check_regs();
    chk("trig_level", trig_level, mreg[0]);
    chk("deci_rate", deci_rate, mreg[1]);
    chk("mode_bits", {fir_en, fft_en, trig_edge, wave_run}, mreg[2]);
    chk("v_scale", v_scale, mreg[3]);
    chk("trig_line", trig_line, mreg[4]);
    chk("err_cnt", err_cnt, merr);
  endtask

  // Entered and left at a negedge; the strobe is sampled on the posedge in between.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic collect(input bit toggle);
    int n = 0;
    bit held_v = 0;
    bit stable = 1;
    logic [7:0] held = 8'h00;
    for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
      tx_ready = toggle ? ~tx_ready : 1'($urandom_range(0, 1));
      if (held_v && (!tx_valid || tx_data !== held)) stable = 0;
      if (tx_valid) begin
        if (tx_ready) begin
          got[n] = tx_data; n++; held_v = 0;
        end else begin
          held = tx_data; held_v = 1;
        end
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("resp_count", n, 5);
    chk("resp_stable", stable, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("resp_byte%0d", i), got[i], exp_resp[i]);
    chk("tx_valid_after_resp", tx_valid, 0);
  endtask

  task automatic do_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                          input logic [7:0] k, input bit toggle);
    bit resp;
    model_frame(c, h, l, k, resp);
    send_byte(8'h55); send_byte(c); send_byte(h); send_byte(l); send_byte(k);
    if (resp) begin
      chk("tx_valid_rise", tx_valid, 1);
      collect(toggle);
    end else begin
      chk("no_tx", tx_valid, 0);
    end
    check_regs();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    @(negedge clk);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] c, h, l, k, noise;
    int kind;
    int unsigned a;
    sys_rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    ad_freq = 20'h0; ad_vpp = 8'h0; ad_max = 8'h0; ad_min = 8'h0;
    model_reset();
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
    check_regs();
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 0);

    // Directed write: trig_level must change exactly one cycle after CHK.
    do_frame(8'h00, 8'h00, 8'h80, 8'h80, 1'b0);
    do_frame(8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
    do_frame(8'h02, 8'h00, 8'h0C, 8'h0E, 1'b0);

    ad_max = 8'hF0; ad_min = 8'h10;
    do_frame(8'h93, 8'h00, 8'h00, 8'h93, 1'b1);

    do_frame(8'h00, 8'h00, 8'h80, 8'h81, 1'b0);
    do_frame(8'h10, 8'h00, 8'h01, 8'h11, 1'b0);
    chk("err_after_rejects", err_cnt, 2);

    // Timeout boundary: no reject after TMO-1 idle cycles, reject on the next.
    send_byte(8'h55); send_byte(8'h04);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_not_yet", err_cnt, merr);
    @(negedge clk);
    model_err();
    chk("tmo_reject", err_cnt, merr);
    do_frame(8'h04, 8'h01, 8'h2C, 8'h29, 1'b0);

    // A byte on the timeout cycle keeps the frame alive.
    send_byte(8'h55); send_byte(8'h03);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h00); send_byte(8'h07); send_byte(8'h04);
    mreg[3] = 7;
    check_regs();

    // Byte arriving during the response aborts it.
    send_byte(8'h55); send_byte(8'h92); send_byte(8'h00); send_byte(8'h00); send_byte(8'h92);
    chk("resp_pending", tx_valid, 1);
    send_byte(8'h55);
    model_err();
    chk("resp_aborted", tx_valid, 0);
    check_regs();

    // Randomized frames.
    for (int it = 0; it < 40; it++) begin
      ad_freq = 20'($urandom); ad_vpp = 8'($urandom); ad_max = 8'($urandom); ad_min = 8'($urandom);
      noise = 8'($urandom);
      if (noise == 8'h55) noise = 8'h00;
      send_byte(noise);
      kind = int'($urandom_range(0, 4));
      h = 8'($urandom); l = 8'($urandom);
      case (kind)
        0: c = 8'($urandom_range(0, 4));
        1: begin a = $urandom_range(0, 8); c = 8'h80 | 8'((a < 5) ? a : a + 11); end
        2: c = 8'($urandom);
        3: begin
          a = $urandom_range(0, 1) ? $urandom_range(5, 15) : $urandom_range(20, 127);
          c = 8'(a) | (8'($urandom_range(0, 1)) << 7);
        end
        default: c = 8'(16 + $urandom_range(0, 3));
      endcase
      k = c ^ h ^ l;
      if (kind == 2) k = k ^ 8'($urandom_range(1, 255));
      do_frame(c, h, l, k, 1'b0);
    end

    // Saturation of the reject counter.
    for (int i = 0; i < 260; i++) begin
      model_err();
      send_byte(8'h55); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    end
    chk("err_saturated", err_cnt, 255);
    chk("err_model_saturated", err_cnt, merr);

    // Reset in the middle of a response.
    send_byte(8'h55); send_byte(8'h93); send_byte(8'h00); send_byte(8'h00); send_byte(8'h93);
    chk("mid_resp_valid", tx_valid, 1);
    do_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    check_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
